alu_rs_scheduler: RTL and testbench

//  Sequences the pool of ALU reservation stations around one shared ALU and the CDB.

---
 rtl/alu_rs_scheduler.sv | 160 ++++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// ALU reservation-station scheduler.
// Picks a free station for each dispatched ALU op, starts one ready station at
// a time on the shared ALU (round-robin), and holds the result until the CDB
// arbiter grants the broadcast.
//
// Handshakes:
//   issue  : an op is loaded when issue_valid && issue_ready at a rising edge;
//            issue_ld is the one-hot load strobe for that same edge.
//   cdb    : cdb_req stays high (and alu_sel stable) until the edge where
//            cdb_gnt is high; the result is consumed at that edge.
module alu_rs_scheduler #(
  parameter  int NUM_RS  = 3,
  parameter  int ALU_LAT = 1,
  localparam int SELW    = $clog2(NUM_RS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              issue_valid,
  output logic              issue_ready,
  output logic [NUM_RS-1:0] issue_ld,
  input  logic [NUM_RS-1:0] rs_busy,
  input  logic [NUM_RS-1:0] rs_ready,
  output logic [NUM_RS-1:0] exec_start,
  output logic [SELW-1:0]   alu_sel,
  output logic              cdb_req,
  input  logic              cdb_gnt,
  output logic [1:0]        dbg_state,
  output logic [SELW-1:0]   dbg_rr_ptr
);

  localparam int                LATW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LATW-1:0]   LAT_LOAD = LATW'(ALU_LAT - 1);
  localparam logic [SELW-1:0]   LAST_IDX = SELW'(NUM_RS - 1);
  localparam logic [NUM_RS-1:0] ONE_HOT0 = NUM_RS'(1);

  generate
    if (NUM_RS < 2) begin : g_bad_num_rs
      $error("alu_rs_scheduler: NUM_RS must be >= 2");
    end
    if (ALU_LAT < 1) begin : g_bad_alu_lat
      $error("alu_rs_scheduler: ALU_LAT must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SELW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [SELW-1:0]   alu_sel_q, alu_sel_d;
  logic [LATW-1:0]   lat_cnt_q, lat_cnt_d;

  logic [NUM_RS-1:0] free;
  logic [NUM_RS-1:0] issue_oh;
  logic [NUM_RS-1:0] elig;
  logic [NUM_RS-1:0] start_oh;
  logic              found_hi, found_lo;
  logic [SELW-1:0]   pick_hi, pick_lo, pick_idx;

  // Issue path: lowest-index free station gets the load strobe.
  always_comb begin
    free     = ~rs_busy;
    issue_oh = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (free[i]) begin
        issue_oh    = '0;
        issue_oh[i] = 1'b1;
      end
    end
    issue_ready = rst_n & (|free) & ~flush;
    issue_ld    = (issue_valid & issue_ready) ? issue_oh : '0;
  end

  // Round-robin pick: lowest eligible index at/after rr_ptr, else wrap to lowest overall.
  always_comb begin
    elig     = rs_ready & rs_busy;
    found_hi = 1'b0;
    found_lo = 1'b0;
    pick_hi  = '0;
    pick_lo  = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found_lo = 1'b1;
        pick_lo  = SELW'(i);
        if (SELW'(i) >= rr_ptr_q) begin
          found_hi = 1'b1;
          pick_hi  = SELW'(i);
        end
      end
    end
    pick_idx = found_hi ? pick_hi : pick_lo;
  end

  // Next-state logic; flush overrides everything and drops any pending result.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    alu_sel_d = alu_sel_q;
    lat_cnt_d = lat_cnt_q;
    start_oh  = '0;
    if (flush) begin
      state_d   = ST_IDLE;
      rr_ptr_d  = '0;
      alu_sel_d = '0;
      lat_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (found_lo) begin
            start_oh  = ONE_HOT0 << pick_idx;
            alu_sel_d = pick_idx;
            lat_cnt_d = LAT_LOAD;
            state_d   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (lat_cnt_q == '0) begin
            state_d = ST_RESULT;
          end else begin
            lat_cnt_d = lat_cnt_q - 1'b1;
          end
        end
        ST_RESULT: begin
          if (cdb_gnt) begin
            state_d  = ST_IDLE;
            rr_ptr_d = (alu_sel_q == LAST_IDX) ? '0 : alu_sel_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      alu_sel_q <= '0;
      lat_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      alu_sel_q <= alu_sel_d;
      lat_cnt_q <= lat_cnt_d;
    end
  end

  // exec_start is combinational from IDLE, so reset must also gate it.
  assign exec_start = start_oh & {NUM_RS{rst_n}};
  assign cdb_req    = (state_q == ST_RESULT);
  assign alu_sel    = alu_sel_q;
  assign dbg_state  = state_q;
  assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Bench for alu_rs_scheduler: two instances (ALU_LAT=1 and ALU_LAT=3) share
// stimulus; a timestamp-style model predicts every output each cycle, and
// directed literal checks pin the model to hand-computed values.
module tb_alu_rs_scheduler;

  localparam int N    = 3;
  localparam int SW   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush;
  logic         issue_valid;
  logic         cdb_gnt;
  logic [N-1:0] rs_busy;
  logic [N-1:0] rs_ready;

  logic          issue_ready [2];
  logic [N-1:0]  issue_ld    [2];
  logic [N-1:0]  exec_start  [2];
  logic [SW-1:0] alu_sel     [2];
  logic          cdb_req     [2];
  logic [1:0]    dbg_state   [2];
  logic [SW-1:0] dbg_rr_ptr  [2];

  int total = 0;
  int bad   = 0;

  alu_rs_scheduler #(.NUM_RS(N), .ALU_LAT(LAT0)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready[0]), .issue_ld(issue_ld[0]),
    .rs_busy(rs_busy), .rs_ready(rs_ready),
    .exec_start(exec_start[0]), .alu_sel(alu_sel[0]),
    .cdb_req(cdb_req[0]), .cdb_gnt(cdb_gnt),
    .dbg_state(dbg_state[0]), .dbg_rr_ptr(dbg_rr_ptr[0])
  );

  alu_rs_scheduler #(.NUM_RS(N), .ALU_LAT(LAT1)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready[1]), .issue_ld(issue_ld[1]),
    .rs_busy(rs_busy), .rs_ready(rs_ready),
    .exec_start(exec_start[1]), .alu_sel(alu_sel[1]),
    .cdb_req(cdb_req[1]), .cdb_gnt(cdb_gnt),
    .dbg_state(dbg_state[1]), .dbg_rr_ptr(dbg_rr_ptr[1])
  );

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One op in flight per instance: active flag, cycles since start, owner, rr pointer.
  bit m_active [2] = '{1'b0, 1'b0};
  int m_age    [2] = '{0, 0};
  int m_owner  [2] = '{0, 0};
  int m_ptr    [2] = '{0, 0};

  logic         exp_ready;
  logic [N-1:0] exp_ld;
  logic [N-1:0] exp_exec [2];
  logic         exp_req  [2];
  int           exp_pick [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  always_comb begin
    logic [N-1:0] free_v;
    logic [N-1:0] elig_v;
    free_v    = ~rs_busy;
    elig_v    = rs_busy & rs_ready;
    exp_ready = rst_n && (free_v != '0) && !flush;
    exp_ld    = (exp_ready && issue_valid) ? (free_v & (~free_v + 1'b1)) : '0;
    for (int k = 0; k < 2; k++) begin
      exp_pick[k] = -1;
      exp_exec[k] = '0;
      exp_req[k]  = m_active[k] && (m_age[k] >= lat_of(k));
      if (rst_n && !flush && !m_active[k]) begin
        for (int i = 0; i < N; i++) begin
          if (exp_pick[k] < 0 && elig_v[(m_ptr[k] + i) % N]) exp_pick[k] = (m_ptr[k] + i) % N;
        end
      end
      if (exp_pick[k] >= 0) exp_exec[k] = {{(N-1){1'b0}}, 1'b1} << exp_pick[k];
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n || flush) begin
        m_active[k] <= 1'b0;
        m_age[k]    <= 0;
        m_owner[k]  <= 0;
        m_ptr[k]    <= 0;
      end else if (exp_exec[k] != '0) begin
        m_active[k] <= 1'b1;
        m_age[k]    <= 0;
        m_owner[k]  <= exp_pick[k];
      end else if (exp_req[k] && cdb_gnt) begin
        m_active[k] <= 1'b0;
        m_ptr[k]    <= (m_owner[k] + 1) % N;
      end else if (m_active[k]) begin
        m_age[k]    <= m_age[k] + 1;
      end
    end
  end

  // Per-cycle compare of both instances against the model, mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m%0d_issue_ready", k), 32'(issue_ready[k]), 32'(exp_ready));
      check($sformatf("m%0d_issue_ld", k),    32'(issue_ld[k]),    32'(exp_ld));
      check($sformatf("m%0d_exec_start", k),  32'(exec_start[k]),  32'(exp_exec[k]));
      check($sformatf("m%0d_cdb_req", k),     32'(cdb_req[k]),     32'(exp_req[k]));
      check($sformatf("m%0d_alu_sel", k),     32'(alu_sel[k]),     32'(m_owner[k]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  // ---------------- directed stimulus ----------------
  logic [N-1:0] rr_order [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; cdb_gnt = 1'b0;
    rs_busy = '0; rs_ready = '0;

    // Reset state
    mid();
    for (int k = 0; k < 2; k++) begin
      check("rst_issue_ready", 32'(issue_ready[k]), 32'd0);
      check("rst_exec_start",  32'(exec_start[k]),  32'd0);
      check("rst_cdb_req",     32'(cdb_req[k]),     32'd0);
      check("rst_alu_sel",     32'(alu_sel[k]),     32'd0);
    end
    tick();
    rst_n = 1'b1;

    // Issue path: lowest free station
    issue_valid = 1'b1; rs_busy = 3'b000;
    mid();
    check("t1_ready_000", 32'(issue_ready[0]), 32'd1);
    check("t1_ld_000",    32'(issue_ld[0]),    32'b001);
    tick(); rs_busy = 3'b011;
    mid();
    check("t1_ld_011",    32'(issue_ld[0]),    32'b100);
    tick(); rs_busy = 3'b111;
    mid();
    check("t1_ready_111", 32'(issue_ready[0]), 32'd0);
    check("t1_ld_111",    32'(issue_ld[0]),    32'b000);

    // Start, hold result without grant, then grant and pick next
    tick(); issue_valid = 1'b0; rs_busy = 3'b101; rs_ready = 3'b101;
    mid();
    check("t2_start_lat1", 32'(exec_start[0]), 32'b001);
    check("t2_start_lat3", 32'(exec_start[1]), 32'b001);
    tick();
    mid();
    check("t2_exec_sel",   32'(alu_sel[0]),    32'd0);
    check("t2_exec_req",   32'(cdb_req[0]),    32'd0);
    check("t2_exec_start", 32'(exec_start[0]), 32'd0);
    tick();
    for (int r = 0; r < 3; r++) begin
      mid();
      check("t2_hold_req",   32'(cdb_req[0]),    32'd1);
      check("t2_hold_start", 32'(exec_start[0]), 32'd0);
      tick();
    end
    cdb_gnt = 1'b1;
    mid();
    check("t2_gnt_req", 32'(cdb_req[0]), 32'd1);
    tick();
    cdb_gnt = 1'b0;
    mid();
    check("t2_next_lat1", 32'(exec_start[0]), 32'b100);
    check("t2_next_lat3", 32'(exec_start[1]), 32'b100);
    tick();
    rs_busy = '0; rs_ready = '0; cdb_gnt = 1'b1;
    repeat (6) tick();

    // Round-robin order and spacing with grant tied high; ALU_LAT=3 latency
    rs_busy = 3'b111; rs_ready = 3'b111; cdb_gnt = 1'b1;
    for (int k = 0; k < 10; k++) begin
      mid();
      if (k % 3 == 0) check("t3_rr_start", 32'(exec_start[0]), 32'(rr_order[k / 3]));
      else            check("t3_rr_gap",   32'(exec_start[0]), 32'd0);
      if (k == 0)             check("t4_start",    32'(exec_start[1]), 32'b001);
      if (k >= 1 && k <= 3)   check("t4_req_early", 32'(cdb_req[1]),   32'd0);
      if (k == 4)             check("t4_req_first", 32'(cdb_req[1]),   32'd1);
      if (k == 5)             check("t4_next",     32'(exec_start[1]), 32'b010);
      tick();
    end

    // Flush in RESULT with a same-cycle grant
    rs_ready = '0; cdb_gnt = 1'b0;
    tick();
    flush = 1'b1; cdb_gnt = 1'b1; issue_valid = 1'b1; rs_busy = 3'b011; rs_ready = 3'b011;
    mid();
    check("t5_req_in_flush",  32'(cdb_req[0]),     32'd1);
    check("t5_start0_flush",  32'(exec_start[0]),  32'd0);
    check("t5_start1_flush",  32'(exec_start[1]),  32'd0);
    check("t5_ld_flush",      32'(issue_ld[0]),    32'd0);
    check("t5_ready_flush",   32'(issue_ready[0]), 32'd0);
    tick();
    flush = 1'b0; cdb_gnt = 1'b0; issue_valid = 1'b0; rs_ready = '0; rs_busy = 3'b111;
    mid();
    check("t5_req_after", 32'(cdb_req[0]),    32'd0);
    check("t5_rr_ptr",    32'(dbg_rr_ptr[0]), 32'd0);
    tick();
    rs_ready = 3'b111;
    mid();
    check("t5_pick_lat1", 32'(exec_start[0]), 32'b001);
    check("t5_pick_lat3", 32'(exec_start[1]), 32'b001);
    tick();
    rs_ready = '0; cdb_gnt = 1'b1;
    tick();
    tick();
    cdb_gnt = 1'b0; rs_ready = 3'b100;
    mid();
    check("t6_pick", 32'(exec_start[0]), 32'b100);
    tick();

    // Asynchronous reset mid-EXEC (lat1) / mid-RESULT (lat3)
    rs_ready = '0; rs_busy = 3'b000; issue_valid = 1'b1;
    mid();
    check("t6_sel_before", 32'(alu_sel[0]),  32'd2);
    check("t6_ld_before",  32'(issue_ld[0]), 32'b001);
    check("t6_req_before", 32'(cdb_req[1]),  32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check("t6_rst_req",   32'(cdb_req[k]),     32'd0);
      check("t6_rst_start", 32'(exec_start[k]),  32'd0);
      check("t6_rst_ld",    32'(issue_ld[k]),    32'd0);
      check("t6_rst_ready", 32'(issue_ready[k]), 32'd0);
      check("t6_rst_sel",   32'(alu_sel[k]),     32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1; issue_valid = 1'b0; rs_busy = 3'b010; rs_ready = 3'b010;
    mid();
    check("t6_idle_lat1", 32'(exec_start[0]), 32'b010);
    check("t6_idle_lat3", 32'(exec_start[1]), 32'b010);
    check("t6_idle_req",  32'(cdb_req[0]),    32'd0);
    tick();
    rs_busy = '0; rs_ready = '0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
